// File: rtl/ones_count_accumulator_pkg.sv
// ============================================================================
// Module   : ones_pkg
// Brief    : Shared types and helpers for the ones-count frame accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ones_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int OC_W = 2;

  function automatic int sum_width(input int words);
    return $clog2(3 * words + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ones_count_accumulator_frame_counter.sv
// ============================================================================
// Module   : oc_frame_counter
// Brief    : Word counter with clear and enable; tc flags the last word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module oc_frame_counter #(
  parameter int WORDS = 8,
  parameter int CNT_W = $clog2(WORDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(WORDS - 1));

endmodule

`default_nettype wire

// File: rtl/ones_count_accumulator.sv
// ============================================================================
// Module   : ones_count_accumulator
// Brief    : Sums 2-bit ones counts over a frame of WORDS words, holds the
//            total on a valid/ready output until the consumer accepts it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ones_count_accumulator
  import ones_pkg::*;
#(
  parameter int WORDS = 8,
  localparam int SUM_W = sum_width(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y1,
  input  logic             y0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;
  logic             cnt_clr;
  logic             accept;
  logic             last_word;

  assign accept = in_valid && (state_q == ACC);

  oc_frame_counter #(
    .WORDS (WORDS)
  ) u_frame_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (accept),
    .tc  (last_word)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          sum_d   = '0;
          cnt_clr = 1'b1;
        end
      end
      ACC: begin
        if (accept) begin
          sum_d = sum_q + {{(SUM_W - OC_W){1'b0}}, y1, y0};
          if (last_word) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
    end
  end

  // Handshake outputs decode from state only, keeping inputs off output paths.
  assign in_ready  = (state_q == ACC);
  assign sum_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_ones_count_accumulator.sv
// ============================================================================
// Module   : tb_ones_count_accumulator
// Brief    : Directed bench; 3-bit words pass through a ones-counter model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ones_count_accumulator;

  localparam int WORDS = 8;
  localparam int SUM_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             y1 = 1'b0;
  logic             y0 = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SUM_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready = 1'b0;
  logic             busy;

  int vectors = 0;
  int errors  = 0;

  ones_count_accumulator #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .y1        (y1),
    .y0        (y0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upstream 3-input ones counter: full-adder sum/carry.
  task automatic drive_word(input logic [2:0] w);
    y0 = w[0] ^ w[1] ^ w[2];
    y1 = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
  endtask

  task automatic feed(input logic [2:0] w);
    in_valid = 1'b1;
    drive_word(w);
    step();
    in_valid = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    chk("rst_sum", 32'(sum), 0);
    chk("rst_valid", 32'(sum_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    step();

    // Reset mid-frame
    begin_frame();
    chk("start_in_ready", 32'(in_ready), 1);
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) feed(3'b111);
    chk("partial_sum", 32'(sum), 9);
    rst = 1'b1;
    #1;
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    step();
    rst = 1'b0;
    step();
    begin_frame();
    for (int i = 0; i < WORDS; i++) feed(3'b100);
    chk("after_rst_valid", 32'(sum_valid), 1);
    chk("after_rst_sum", 32'(sum), 8);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;

    // All ones
    begin_frame();
    for (int i = 0; i < WORDS - 1; i++) feed(3'b111);
    chk("ones_valid_early", 32'(sum_valid), 0);
    feed(3'b111);
    chk("ones_valid", 32'(sum_valid), 1);
    chk("ones_sum", 32'(sum), 24);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk("ones_idle_valid", 32'(sum_valid), 0);
    chk("ones_idle_busy", 32'(busy), 0);
    chk("ones_idle_sum_kept", 32'(sum), 24);

    // Mixed counts 0,1,2,3,1,2,0,3 with bubbles after words 2 and 5
    begin_frame();
    chk("mix_sum_cleared", 32'(sum), 0);
    feed(3'b000);
    feed(3'b010);
    step();
    chk("mix_bubble1_ready", 32'(in_ready), 1);
    chk("mix_bubble1_sum", 32'(sum), 1);
    feed(3'b110);
    feed(3'b111);
    feed(3'b001);
    step();
    chk("mix_bubble2_sum", 32'(sum), 7);
    feed(3'b101);
    feed(3'b000);
    chk("mix_valid_early", 32'(sum_valid), 0);
    feed(3'b111);
    chk("mix_valid", 32'(sum_valid), 1);
    chk("mix_sum", 32'(sum), 12);

    // Backpressure in HOLD while upstream keeps offering 2'b11
    in_valid = 1'b1;
    drive_word(3'b111);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sum", 32'(sum), 12);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(sum_valid), 1);
    end
    in_valid  = 1'b0;
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk("bp_release_valid", 32'(sum_valid), 0);
    chk("bp_release_busy", 32'(busy), 0);

    // Start pulses while busy are ignored
    begin_frame();
    for (int i = 0; i < 3; i++) feed(3'b001);
    start = 1'b1;
    feed(3'b001);
    start = 1'b0;
    chk("busy_start_sum", 32'(sum), 4);
    chk("busy_start_ready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) feed(3'b001);
    chk("busy_hold_valid", 32'(sum_valid), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hold_start_valid", 32'(sum_valid), 1);
    chk("hold_start_sum", 32'(sum), 8);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk("hold_start_idle", 32'(busy), 0);

    // Back-to-back frames, handshake on the first HOLD cycle
    begin_frame();
    for (int i = 0; i < WORDS; i++) feed(3'b000);
    chk("a_valid", 32'(sum_valid), 1);
    chk("a_sum", 32'(sum), 0);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk("a_one_cycle_valid", 32'(sum_valid), 0);
    begin_frame();
    chk("b_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < WORDS; i++) feed(3'b010);
    chk("b_valid", 32'(sum_valid), 1);
    chk("b_sum", 32'(sum), 8);
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
    chk("b_idle", 32'(sum_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ones_count_accumulator.md
# ones_count_accumulator

Sequential stage directly downstream of the 3-input ones counter. It consumes one 2-bit count {y1,y0} per accepted cycle and sums the counts over a frame of WORDS consecutive 3-bit words. It presents the frame total (the number of 1s in a 3·WORDS-bit vector) on a valid/ready output. Frames start on a start pulse. Output is held until the consumer accepts it.

## Interface
- WORDS, 8, number of 3-bit words (ones-counter results) per frame; legal range 2..64.
- SUM_W, $clog2(3*WORDS+1), width of the frame total; derived, not overridden.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begins a frame; honoured only in IDLE.
- y1  input  1  count MSB from the ones counter.
- y0  input  1  count LSB from the ones counter.
- in_valid  input  1  {y1,y0} carries a valid count this cycle.
- in_ready  output  1  block accepts a count this cycle.
- sum  output  SUM_W  frame total; valid while sum_valid=1.
- sum_valid  output  1  frame total available.
- sum_ready  input  1  consumer takes sum this cycle.
- busy  output  1  high in ACC or HOLD.

## Operation
- States: IDLE, ACC, HOLD.
- IDLE:
  - in_ready=0, sum_valid=0, busy=0.
  - start=1 → ACC next cycle. sum is cleared to 0 and word count cnt is cleared to 0 on the same edge.
- ACC:
  - in_ready=1, busy=1.
  - Accept: in_valid && in_ready. On accept, sum ← sum + {y1,y0} (zero-extended to SUM_W) and cnt ← cnt+1.
  - Accept with cnt==WORDS-1 → HOLD.
  - in_valid=0 cycles are bubbles; no state change.
- HOLD:
  - sum_valid=1, in_ready=0, busy=1.
  - sum is frozen.
  - sum_ready=1 → IDLE next cycle. sum keeps its value in IDLE until the next start.
- start outside IDLE is ignored; there is no restart mid-frame.
- Arithmetic:
  - {y1,y0}=2'b11 (three ones) is a legal input.
  - The maximum total is 3·WORDS, which always fits in SUM_W, so overflow is impossible by construction.
  - cnt is $clog2(WORDS) bits wide and never wraps inside a frame.
- Reset (any cycle, including mid-frame or during HOLD) → IDLE, sum=0, cnt=0, sum_valid=0, in_ready=0, busy=0. Partial frame is discarded.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from in_valid, sum_ready or start to any output.
- start at edge k → in_ready=1 from cycle k+1.
- Last accept at edge n → sum_valid=1 and final sum visible from cycle n+1.
- Minimum frame, back-to-back:
  - 1 cycle for start, WORDS accept cycles, 1 or more HOLD cycles.
  - Next start is honoured no earlier than the first IDLE cycle after the HOLD handshake.
- sum_ready=1 on the first HOLD cycle → exactly one cycle of sum_valid.
- sum_ready is ignored outside HOLD. in_valid is ignored outside ACC.

## Structure
- Shared package ones_pkg:
  - state typedef enum logic [1:0] {IDLE, ACC, HOLD}.
  - localparam OC_W=2 (ones-counter result width).
  - Function sum_width(words) returning $clog2(3*words+1).
- One sub-module, oc_frame_counter: word counter with clear, enable and terminal-count output (tc = cnt==WORDS-1).
- Top module holds the FSM, the sum register and the handshake decode.
- Integration test bench instantiates the ones counter ahead of this block, with {y1,y0} wired straight through.

## Test plan
- Reset mid-frame:
  - WORDS=8, start, feed counts 3,3,3.
  - Assert rst for 1 cycle → sum=0, busy=0, in_ready=0 immediately.
  - A new frame then gives the correct total.
- All ones:
  - WORDS=8, start, 8 consecutive accepts of 2'b11.
  - → sum_valid one cycle after the 8th accept, sum=24 (5'b11000).
- Mixed values with bubbles:
  - Counts 0,1,2,3,1,2,0,3 with in_valid=0 inserted after words 2 and 5.
  - → sum=12, and the bubbles do not advance cnt.
- Backpressure:
  - Hold sum_ready=0 for 5 cycles in HOLD while driving in_valid=1 with 2'b11.
  - → sum stays constant, in_ready=0, nothing accepted.
  - sum_ready=1 → IDLE next cycle.
- Start while busy:
  - Pulse start during ACC (word 4) and again during HOLD.
  - → no restart; frame total is unaffected (e.g. all-1 counts give sum=8).
- Back-to-back frames:
  - Frame A all 2'b00 → sum=0. Frame B all 2'b01 → sum=8.
  - Start issued on the first IDLE cycle after the A handshake; both totals are correct.
